fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving instruction queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h00000000, giving the first fetch address after reset.
REQ-003 SHALL have port i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port o_imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port i_imem_req_ready  input  1  memory accepts request.
REQ-007 SHALL have port o_imem_req_addr  output  32  word-aligned fetch address.
REQ-008 SHALL have port i_imem_rsp_valid  input  1  response valid; responses arrive in request order and cannot be stalled.
REQ-009 SHALL have port i_imem_rsp_data  input  32  fetched instruction word.
REQ-010 SHALL have port i_redirect_valid  input  1  control-flow redirect/flush.
REQ-011 SHALL have port i_redirect_pc  input  32  redirect target; bits [1:0] ignored.
REQ-012 SHALL have port o_inst_valid  output  1  instruction available to decoder.
REQ-013 SHALL have port o_inst  output  32  instruction word driven to decoder i_inst.
REQ-014 SHALL have port o_inst_pc  output  32  address of o_inst.
REQ-015 SHALL have port i_inst_ready  input  1  decoder consumes o_inst.

Function
REQ-016 SHALL hold fetch PC; o_imem_req_addr = {pc[31:2], 2'b00}; pc advances by 4 on each request handshake (valid && ready), wrapping 32'hFFFFFFFC -> 0.
REQ-017 SHALL track outstanding (accepted, unanswered requests) and occupancy (queue entries), each $clog2(DEPTH+1) bits.
REQ-018 SHALL assert o_imem_req_valid only when outstanding + occupancy < DEPTH, not in reset, and i_redirect_valid low (credit rule; a response is never lost).
REQ-019 SHALL push {rsp_data, pc-of-request} into FIFO on i_imem_rsp_valid when drop count is 0; response PC tracked by a separate response-PC register advancing by 4 per accepted response.
REQ-020 SHALL present FIFO head on o_inst/o_inst_pc with o_inst_valid = occupancy != 0; pop on o_inst_valid && i_inst_ready.
REQ-021 SHALL support simultaneous push and pop in one cycle; occupancy unchanged; full queue never receives a push (guaranteed by REQ-018).
REQ-022 On i_redirect_valid SHALL: empty queue, set pc and response-PC to {i_redirect_pc[31:2],2'b00}, set drop count = outstanding minus 1 if a response arrives that same cycle, else outstanding; o_inst_valid forced 0 that cycle.
REQ-023 While drop count > 0 SHALL discard each arriving response and decrement drop count and outstanding; no push.
REQ-024 Redirect while drop count > 0 SHALL recompute drop count per REQ-022 (total outstanding).
REQ-025 Redirect-to-first-request latency: o_imem_req_valid high with new address the cycle after redirect, subject to REQ-018.
REQ-026 Response-to-o_inst_valid latency SHALL be 1 cycle (without bypass).

Reset
REQ-027 During i_rst SHALL drive o_imem_req_valid=0, o_inst_valid=0; pc and response-PC = RESET_PC; outstanding, occupancy, drop count = 0.
REQ-028 Reset mid-operation SHALL abandon in-flight requests; memory is reset by the same i_rst, so no stale responses are expected.
REQ-029 First request SHALL be issued in the first cycle with i_rst low.

Configuration
REQ-030 With FETCH_BYPASS_EN defined: when occupancy = 0 and drop count = 0, an arriving response SHALL drive o_inst_valid/o_inst/o_inst_pc in the same cycle; if i_inst_ready is high it is not written to the queue, else it is pushed.
REQ-031 Without FETCH_BYPASS_EN: all responses go through the queue; latency per REQ-026; no combinational path from i_imem_rsp_* to o_inst_*.

Verification
REQ-032 Reset release, ready=1, single-cycle memory, decoder ready=1 -> addresses 0x0,0x4,0x8,... consecutive; o_inst_pc follows with 1-cycle response latency (0 with bypass).
REQ-033 Decoder i_inst_ready=0, DEPTH=4 -> exactly 4 requests issued, then o_imem_req_valid stays 0; releasing ready pops 4 in order at pcs 0x0..0xC.
REQ-034 Memory latency 3 cycles, 2 outstanding, redirect to 0x00000102 -> both late responses dropped, next request addr 0x00000100, next o_inst_pc 0x100.
REQ-035 Redirect coincident with response arrival and pop -> that response dropped, o_inst_valid 0 that cycle, drop count = outstanding-1.
REQ-036 Redirect to 0xFFFFFFF8, free-running -> requests 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-037 Assert i_rst with 3 queued entries -> next cycle o_inst_valid=0, o_imem_req_valid=0; after release first address = RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end with a credit-limited request port,
// an in-order response FIFO and redirect/flush handling with response dropping.
// Optional feature macro: FETCH_BYPASS_EN. When it is defined, a response that
// arrives to an empty queue is forwarded straight to the decoder in the same
// cycle. When it is undefined, every response is registered in the queue first.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW1 = CW + 1;
  localparam logic [CW:0] DEPTH_C = CW1'(DEPTH);

  // Control state (reset)
  logic [31:0]   r_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_occ;
  logic [CW-1:0] r_drop;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;

  // Queue storage (data only, never reset)
  logic [31:0]   r_mem_inst [DEPTH];
  logic [31:0]   r_mem_pc   [DEPTH];

  logic [CW:0]   w_credit;
  logic          w_req_fire;
  logic          w_rsp_live;
  logic          w_nonempty;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_redirect_tgt;
  logic [1:0]    w_unused_redirect_lsb;

  assign w_redirect_tgt        = {i_redirect_pc[31:2], 2'b00};
  assign w_unused_redirect_lsb = i_redirect_pc[1:0];

  // Credit rule: outstanding requests plus queued entries never exceed DEPTH,
  // so every response that comes back has a slot waiting for it.
  assign w_credit         = {1'b0, r_out} + {1'b0, r_occ};
  assign o_imem_req_valid = !i_rst && !i_redirect_valid && (w_credit < DEPTH_C);
  assign o_imem_req_addr  = {r_pc[31:2], 2'b00};
  assign w_req_fire       = o_imem_req_valid && i_imem_req_ready;

  // A response is live only when no stale responses remain to be discarded.
  assign w_rsp_live = i_imem_rsp_valid && (r_drop == '0);
  assign w_nonempty = (r_occ != '0);

`ifdef FETCH_BYPASS_EN
  assign w_bypass  = w_rsp_live && !w_nonempty;
  assign o_inst    = w_nonempty ? r_mem_inst[r_rptr] : i_imem_rsp_data;
  assign o_inst_pc = w_nonempty ? r_mem_pc[r_rptr]   : r_rsp_pc;
`else
  assign w_bypass  = 1'b0;
  assign o_inst    = r_mem_inst[r_rptr];
  assign o_inst_pc = r_mem_pc[r_rptr];
`endif

  assign o_inst_valid = !i_rst && !i_redirect_valid && (w_nonempty || w_bypass);
  assign w_pop        = o_inst_valid && i_inst_ready && w_nonempty;
  // A bypassed response that the decoder takes right away skips the queue.
  assign w_push       = w_rsp_live && !i_redirect_valid && !(w_bypass && i_inst_ready);

  // Control registers: fetch PC, response PC, credit counters, drop count, pointers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc     <= RESET_PC;
      r_rsp_pc <= RESET_PC;
      r_out    <= '0;
      r_occ    <= '0;
      r_drop   <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
    end else if (i_redirect_valid) begin
      // Flush: every request still in flight becomes stale; a response landing
      // this very cycle is already consumed (and thrown away) right here.
      r_pc     <= w_redirect_tgt;
      r_rsp_pc <= w_redirect_tgt;
      r_out    <= r_out - CW'(i_imem_rsp_valid);
      r_drop   <= r_out - CW'(i_imem_rsp_valid);
      r_occ    <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
    end else begin
      if (w_req_fire) begin
        r_pc <= r_pc + 32'd4;
      end
      if (w_rsp_live) begin
        r_rsp_pc <= r_rsp_pc + 32'd4;
      end
      if (i_imem_rsp_valid && (r_drop != '0)) begin
        r_drop <= r_drop - 1'b1;
      end
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_out <= r_out + CW'(w_req_fire) - CW'(i_imem_rsp_valid);
      r_occ <= r_occ + CW'(w_push) - CW'(w_pop);
    end
  end

  // Queue write: instruction word with the address it was fetched from
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_inst[r_wptr] <= i_imem_rsp_data;
      r_mem_pc[r_wptr]   <= r_rsp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios for fetch_queue with an in-order memory
// model of programmable latency and a scoreboard of expected request addresses
// and decoded instruction PCs. Stimulus and the memory model drive on the
// falling edge; the monitor samples 2 time units later.
module tb_fetch_queue;

  logic        clk;
  logic        i_rst;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready;
  logic [31:0] o_imem_req_addr;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        i_inst_ready;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .o_imem_req_valid (o_imem_req_valid),
    .i_imem_req_ready (i_imem_req_ready),
    .o_imem_req_addr  (o_imem_req_addr),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_inst_valid     (o_inst_valid),
    .o_inst           (o_inst),
    .o_inst_pc        (o_inst_pc),
    .i_inst_ready     (i_inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  int lat = 1;
  int cyc = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        pend[$];
  logic [31:0] exp_req[$];
  logic [31:0] exp_pc[$];

  function automatic logic [31:0] fdata(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Memory model: in-order responses, fixed latency, cleared by reset
  always begin
    req_t h;
    @(negedge clk);
    cyc++;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      h = pend.pop_front();
      i_imem_rsp_valid = 1'b1;
      i_imem_rsp_data  = fdata(h.addr);
    end else begin
      i_imem_rsp_valid = 1'b0;
      i_imem_rsp_data  = 32'h0;
    end
    #1;
    if (i_rst) begin
      pend.delete();
    end else if (o_imem_req_valid && i_imem_req_ready) begin
      h.addr = o_imem_req_addr;
      h.due  = cyc + lat;
      pend.push_back(h);
    end
  end

  // Monitor: compare request handshakes and decoder pops against the scoreboard
  always begin
    logic [31:0] e;
    @(negedge clk);
    #2;
    if (!i_rst) begin
      if (o_imem_req_valid && i_imem_req_ready) begin
        req_cnt++;
        if (exp_req.size() > 0) begin
          e = exp_req.pop_front();
          chk("req_addr", o_imem_req_addr, e);
        end
      end
      if (o_inst_valid && i_inst_ready && exp_pc.size() > 0) begin
        e = exp_pc.pop_front();
        chk("inst_pc", o_inst_pc, e);
        chk("inst_word", o_inst, fdata(e));
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Leaves the bench at the falling edge that starts the first post-reset cycle
  task automatic reset_dut();
    i_rst = 1'b1;
    i_redirect_valid = 1'b0;
    step();
    #2;
    chk("rst_req_valid", {31'h0, o_imem_req_valid}, 32'h0);
    chk("rst_inst_valid", {31'h0, o_inst_valid}, 32'h0);
    step();
  endtask

  task automatic end_scn(string nm);
    chk({nm, "_req_left"}, exp_req.size(), 32'h0);
    chk({nm, "_pc_left"}, exp_pc.size(), 32'h0);
    exp_req.delete();
    exp_pc.delete();
  endtask

  initial begin
    i_rst = 1'b1;
    i_imem_req_ready = 1'b1;
    i_redirect_valid = 1'b0;
    i_redirect_pc = 32'h0;
    i_inst_ready = 1'b1;

    // A: streaming, single-cycle memory, decoder always ready
    lat = 1;
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      exp_req.push_back(32'(i * 4));
      exp_pc.push_back(32'(i * 4));
    end
    i_rst = 1'b0;
    #2;
    chk("a_first_req_valid", {31'h0, o_imem_req_valid}, 32'h1);
    chk("a_first_req_addr", o_imem_req_addr, 32'h0);
    chk("a_c0_inst_valid", {31'h0, o_inst_valid}, 32'h0);
    step();
    #2;
`ifdef FETCH_BYPASS_EN
    chk("a_c1_inst_valid", {31'h0, o_inst_valid}, 32'h1);
`else
    chk("a_c1_inst_valid", {31'h0, o_inst_valid}, 32'h0);
    step();
    #2;
    chk("a_c2_inst_valid", {31'h0, o_inst_valid}, 32'h1);
    chk("a_c2_inst_pc", o_inst_pc, 32'h0);
`endif
    repeat (12) step();
    end_scn("a");

    // B: decoder stalled, queue fills, request port throttles to DEPTH
    lat = 1;
    i_inst_ready = 1'b0;
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      exp_req.push_back(32'(i * 4));
      exp_pc.push_back(32'(i * 4));
    end
    req_cnt = 0;
    i_rst = 1'b0;
    repeat (10) step();
    #3;
    chk("b_req_count", 32'(req_cnt), 32'h4);
    chk("b_req_valid_full", {31'h0, o_imem_req_valid}, 32'h0);
    chk("b_head_valid", {31'h0, o_inst_valid}, 32'h1);
    chk("b_head_pc", o_inst_pc, 32'h0);
    step();
    i_inst_ready = 1'b1;
    repeat (10) step();
    end_scn("b");

    // C: latency 3, two requests in flight, redirect to an unaligned target
    lat = 3;
    reset_dut();
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h4);
    exp_req.push_back(32'h100);
    exp_req.push_back(32'h104);
    exp_pc.push_back(32'h100);
    exp_pc.push_back(32'h104);
    exp_pc.push_back(32'h108);
    i_rst = 1'b0;
    step();
    step();
    i_redirect_valid = 1'b1;
    i_redirect_pc = 32'h0000_0102;
    #2;
    chk("c_redir_req_valid", {31'h0, o_imem_req_valid}, 32'h0);
    chk("c_redir_inst_valid", {31'h0, o_inst_valid}, 32'h0);
    step();
    i_redirect_valid = 1'b0;
    #2;
    chk("c_post_redir_valid", {31'h0, o_imem_req_valid}, 32'h1);
    chk("c_post_redir_addr", o_imem_req_addr, 32'h100);
    repeat (12) step();
    end_scn("c");

    // D: redirect in the same cycle a response arrives and the head is ready
    lat = 3;
    reset_dut();
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h4);
    exp_req.push_back(32'h8);
    exp_req.push_back(32'hC);
    exp_req.push_back(32'h200);
    exp_req.push_back(32'h204);
`ifdef FETCH_BYPASS_EN
    exp_pc.push_back(32'h0);
`endif
    exp_pc.push_back(32'h200);
    exp_pc.push_back(32'h204);
    exp_pc.push_back(32'h208);
    i_rst = 1'b0;
    repeat (4) step();
    i_redirect_valid = 1'b1;
    i_redirect_pc = 32'h0000_0200;
    #2;
    chk("d_redir_inst_valid", {31'h0, o_inst_valid}, 32'h0);
    step();
    i_redirect_valid = 1'b0;
    repeat (14) step();
    end_scn("d");

    // E: redirect near the top of the address space, PC wraps to zero
    lat = 1;
    reset_dut();
    exp_req.push_back(32'h0);
    exp_req.push_back(32'hFFFF_FFF8);
    exp_req.push_back(32'hFFFF_FFFC);
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h4);
    exp_pc.push_back(32'hFFFF_FFF8);
    exp_pc.push_back(32'hFFFF_FFFC);
    exp_pc.push_back(32'h0);
    exp_pc.push_back(32'h4);
    i_rst = 1'b0;
    step();
    i_redirect_valid = 1'b1;
    i_redirect_pc = 32'hFFFF_FFF8;
    step();
    i_redirect_valid = 1'b0;
    repeat (10) step();
    end_scn("e");

    // F: reset asserted with three entries queued
    lat = 1;
    i_inst_ready = 1'b0;
    reset_dut();
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h4);
    exp_req.push_back(32'h8);
    exp_req.push_back(32'hC);
    i_rst = 1'b0;
    repeat (4) step();
    i_rst = 1'b1;
    #2;
    chk("f_rst_req_valid", {31'h0, o_imem_req_valid}, 32'h0);
    chk("f_rst_inst_valid", {31'h0, o_inst_valid}, 32'h0);
    step();
    i_rst = 1'b0;
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h4);
    exp_pc.push_back(32'h0);
    exp_pc.push_back(32'h4);
    exp_pc.push_back(32'h8);
    #2;
    chk("f_after_req_valid", {31'h0, o_imem_req_valid}, 32'h1);
    chk("f_after_req_addr", o_imem_req_addr, 32'h0);
    chk("f_after_inst_valid", {31'h0, o_inst_valid}, 32'h0);
    step();
    i_inst_ready = 1'b1;
    repeat (10) step();
    end_scn("f");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
